// File: rtl/fifo_pkg.sv
// Shared FIFO-side definitions: data widths, reader FSM states and the
// byte-lane selection helper used by the byte reader.
package fifo_pkg;

   localparam int DATA_W = 32;
   localparam int BYTE_W = 8;

   // Reader FSM: IDLE (may pop), WAIT (read data arriving), SEND (stream bytes)
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      SEND = 2'd2
   } state_t;

   // Select byte number idx of a word; idx 0 is the first byte sent.
   function automatic logic [BYTE_W-1:0] pick_byte(
      input logic [DATA_W-1:0] word,
      input logic [1:0]        idx,
      input bit                lsb_first
   );
      logic [1:0]        lane;
      logic [BYTE_W-1:0] b;
      lane = lsb_first ? idx : ~idx;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/fifo_byte_reader_if.sv
// FIFO read port plus downstream byte stream seen by the byte reader.
//
// Handshakes:
//   FIFO side  - Read_enable is a one-cycle strobe; data_out is valid on the
//                cycle after the strobe. empty gates the strobe.
//   Byte side  - byte_out/byte_last are meaningful while byte_valid=1 and are
//                held until a cycle with byte_valid=1 and byte_ready=1, which
//                is the single transfer cycle for that byte.
interface fifo_byte_reader_if;
   import fifo_pkg::*;

   logic              empty;
   logic [DATA_W-1:0] data_out;
   logic              Read_enable;
   logic              byte_ready;
   logic [BYTE_W-1:0] byte_out;
   logic              byte_valid;
   logic              byte_last;

   // The reader drives the strobe and the byte stream
   modport master (
      input  empty, data_out, byte_ready,
      output Read_enable, byte_out, byte_valid, byte_last
   );

   // FIFO model / downstream consumer side
   modport slave (
      output empty, data_out, byte_ready,
      input  Read_enable, byte_out, byte_valid, byte_last
   );

endinterface

// File: rtl/fifo_byte_reader.sv
// Pops 32-bit words from a FIFO and streams them out one byte at a time.
// Fixed timing: strobe in cycle N, first byte valid in N+2, and with the
// consumer always ready the next strobe can come in N+6.
module fifo_byte_reader
   import fifo_pkg::*;
#(
   parameter bit LSB_FIRST = 1'b1,
   parameter int CNT_W     = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   fifo_byte_reader_if.master  bus,
   output logic [CNT_W-1:0]    words_read,
   output logic                busy,
   output state_t              state_dbg
);

   state_t            state;
   logic [DATA_W-1:0] word_q;
   logic [1:0]        idx_q;
   logic              valid_q;
   // Low until the first rising edge after reset, so no strobe can appear
   // in the partial cycle in which reset is released.
   logic              started_q;
   logic              xfer;

   assign bus.Read_enable = started_q && (state == IDLE) && enable && !bus.empty;
   assign xfer            = valid_q && bus.byte_ready;

   assign bus.byte_valid  = valid_q;
   assign bus.byte_out    = valid_q ? pick_byte(word_q, idx_q, LSB_FIRST) : '0;
   assign bus.byte_last   = valid_q && (idx_q == 2'd3);
   assign busy            = (state != IDLE);
   assign state_dbg       = state;

   // Reader FSM: pop a word, capture it, then hand out its four bytes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         word_q     <= '0;
         idx_q      <= 2'd0;
         valid_q    <= 1'b0;
         started_q  <= 1'b0;
         words_read <= '0;
      end else begin
         started_q <= 1'b1;
         case (state)
            IDLE: begin
               if (bus.Read_enable) begin
                  state      <= WAIT;
                  words_read <= words_read + 1'b1;
               end
            end
            WAIT: begin
               word_q  <= bus.data_out;
               idx_q   <= 2'd0;
               valid_q <= 1'b1;
               state   <= SEND;
            end
            SEND: begin
               if (xfer) begin
                  idx_q <= idx_q + 2'd1;
                  if (idx_q == 2'd3) begin
                     valid_q <= 1'b0;
                     state   <= IDLE;
                  end
               end
            end
            default: begin
               valid_q <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_byte_reader.sv
// Bench for fifo_byte_reader: two instances run in lockstep from one FIFO
// model (A: LSB first, 4-bit counter; B: MSB first, default counter).
// Expected bytes are queued when words are pushed; a negedge monitor pops
// and compares on every byte transfer and checks per-cycle properties.
module tb_fifo_byte_reader;
   import fifo_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [3:0]  words_read_a;
   logic [15:0] words_read_b;
   logic        busy_a, busy_b;
   state_t      state_dbg_a, state_dbg_b;

   fifo_byte_reader_if bus_a();
   fifo_byte_reader_if bus_b();

   assign bus_b.empty      = bus_a.empty;
   assign bus_b.data_out   = bus_a.data_out;
   assign bus_b.byte_ready = bus_a.byte_ready;

   fifo_byte_reader #(.LSB_FIRST(1'b1), .CNT_W(4)) dut_a (
      .clk(clk), .reset(reset), .enable(enable), .bus(bus_a),
      .words_read(words_read_a), .busy(busy_a), .state_dbg(state_dbg_a)
   );

   fifo_byte_reader #(.LSB_FIRST(1'b0)) dut_b (
      .clk(clk), .reset(reset), .enable(enable), .bus(bus_b),
      .words_read(words_read_b), .busy(busy_b), .state_dbg(state_dbg_b)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] fifo_q[$];
   logic [8:0]  exp_a[$];
   logic [8:0]  exp_b[$];
   int          pops = 0;
   int          seen_a = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // FIFO model: pop on strobe, data appears next cycle; empty refreshed
   // after stimulus has had its chance to push in this cycle.
   always @(posedge clk) begin
      if (reset) pops = 0;
      if (bus_a.Read_enable && fifo_q.size() > 0) begin
         bus_a.data_out <= fifo_q.pop_front();
         pops = pops + 1;
      end
      #2;
      bus_a.empty = (fifo_q.size() == 0);
   end

   // ---------------- monitor ----------------
   int         cyc = 0;
   int         re_cyc = -100;
   logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_re = 1'b0, prev_last = 1'b0;
   logic [7:0] prev_byte = 8'h00;

   // Per-cycle property checks and byte scoreboard
   always @(negedge clk) begin
      logic [8:0] e;
      cyc++;
      if (reset) begin
         prev_valid = 1'b0;
         prev_ready = 1'b0;
         prev_re    = 1'b0;
         seen_a     = 0;
      end else begin
         check("re_a_vs_b", bus_b.Read_enable, bus_a.Read_enable);
         check("valid_a_vs_b", bus_b.byte_valid, bus_a.byte_valid);
         check("words_a", words_read_a, pops % 16);
         check("words_b", words_read_b, pops % 65536);
         check("busy_vs_state", busy_a, state_dbg_a != IDLE);
         if (bus_a.Read_enable) begin
            check("re_single_pulse", prev_re, 1'b0);
            check("re_while_busy", busy_a, 1'b0);
            re_cyc = cyc;
         end
         if (!busy_a) check("idle_valid", bus_a.byte_valid, 1'b0);
         if (!bus_a.byte_valid) begin
            check("zero_byte_a", bus_a.byte_out, 8'h00);
            check("zero_last_a", bus_a.byte_last, 1'b0);
         end
         if (!bus_b.byte_valid) check("zero_byte_b", bus_b.byte_out, 8'h00);
         if (bus_a.byte_valid && !prev_valid) check("latency", cyc - re_cyc, 2);
         if (prev_valid && !prev_ready) begin
            check("hold_valid", bus_a.byte_valid, 1'b1);
            check("hold_byte", bus_a.byte_out, prev_byte);
            check("hold_last", bus_a.byte_last, prev_last);
         end
         if (bus_a.byte_valid && bus_a.byte_ready) begin
            if (exp_a.size() == 0) begin
               check("unexpected_byte_a", 1'b1, 1'b0);
            end else begin
               e = exp_a.pop_front();
               check("byte_a", {bus_a.byte_last, bus_a.byte_out}, e);
            end
            seen_a = (seen_a + 1) % 4;
         end
         if (bus_b.byte_valid && bus_b.byte_ready) begin
            if (exp_b.size() == 0) begin
               check("unexpected_byte_b", 1'b1, 1'b0);
            end else begin
               e = exp_b.pop_front();
               check("byte_b", {bus_b.byte_last, bus_b.byte_out}, e);
            end
         end
         prev_valid = bus_a.byte_valid;
         prev_ready = bus_a.byte_ready;
         prev_re    = bus_a.Read_enable;
         prev_byte  = bus_a.byte_out;
         prev_last  = bus_a.byte_last;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_word(input logic [31:0] w);
      fifo_q.push_back(w);
      for (int i = 0; i < 4; i++) begin
         exp_a.push_back({(i == 3) ? 1'b1 : 1'b0, w[8*i +: 8]});
         exp_b.push_back({(i == 3) ? 1'b1 : 1'b0, w[8*(3-i) +: 8]});
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int max_cyc, input bit rnd);
      int k = 0;
      while ((exp_a.size() != 0 || busy_a) && k < max_cyc) begin
         if (rnd) begin
            bus_a.byte_ready = ($urandom_range(0, 3) != 0);
            enable           = ($urandom_range(0, 4) != 0);
         end
         step();
         k++;
      end
      bus_a.byte_ready = 1'b1;
      enable           = 1'b1;
      check("drain_left", exp_a.size(), 0);
   endtask

   task automatic wait_index(input int idx, input string name);
      int k = 0;
      while (!(seen_a == idx && bus_a.byte_valid) && k < 100) begin
         step();
         k++;
      end
      check(name, (k < 100) ? 1'b1 : 1'b0, 1'b1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_re"},    bus_a.Read_enable, 1'b0);
      check({tag, "_valid"}, bus_a.byte_valid, 1'b0);
      check({tag, "_byte"},  bus_a.byte_out, 8'h00);
      check({tag, "_last"},  bus_a.byte_last, 1'b0);
      check({tag, "_busy"},  busy_a, 1'b0);
      check({tag, "_words"}, words_read_a, 4'd0);
      check({tag, "_state"}, state_dbg_a, IDLE);
      check({tag, "_valid_b"}, bus_b.byte_valid, 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset            = 1'b1;
      enable           = 1'b0;
      bus_a.byte_ready = 1'b0;
      repeat (3) step();
      check_all_zero("reset");

      // Word waiting and enable high during reset: no strobe may appear
      push_word(32'h44332211);
      enable           = 1'b1;
      bus_a.byte_ready = 1'b1;
      repeat (2) step();
      check("re_in_reset", bus_a.Read_enable, 1'b0);
      reset = 1'b0;
      #1;
      check("re_at_release", bus_a.Read_enable, 1'b0);

      // Both byte orders on the same word, consumer always ready
      drain(100, 1'b0);
      check("words_after_first", words_read_a, 4'd1);

      // Consumer stalls for 5 cycles on byte index 1
      push_word(32'h44332211);
      wait_index(1, "reach_idx1");
      bus_a.byte_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("stall_byte", bus_a.byte_out, 8'h22);
         check("stall_valid", bus_a.byte_valid, 1'b1);
         check("stall_re", bus_a.Read_enable, 1'b0);
      end
      bus_a.byte_ready = 1'b1;
      drain(100, 1'b0);

      // Empty FIFO with enable high: nothing happens, then a prompt strobe
      for (int i = 0; i < 20; i++) begin
         step();
         check("empty_re", bus_a.Read_enable, 1'b0);
         check("empty_busy", busy_a, 1'b0);
      end
      push_word($urandom);
      #2;
      check("re_after_empty_falls", bus_a.Read_enable, 1'b1);
      drain(100, 1'b0);

      // Reset in the middle of a word: remaining bytes are dropped
      push_word(32'h88776655);
      wait_index(2, "reach_idx2");
      reset = 1'b1;
      #1;
      check_all_zero("mid_reset");
      void'(exp_a.pop_front());
      void'(exp_a.pop_front());
      void'(exp_b.pop_front());
      void'(exp_b.pop_front());
      repeat (3) step();
      check("no_bytes_in_reset", bus_a.byte_valid, 1'b0);
      reset = 1'b0;
      push_word(32'h0C0B0A09);
      drain(100, 1'b0);

      // 17 random words with random back-pressure and enable: A's counter wraps
      reset = 1'b1;
      repeat (2) step();
      reset = 1'b0;
      for (int i = 0; i < 17; i++) push_word($urandom);
      drain(3000, 1'b1);
      check("wrap_words_a", words_read_a, 4'd1);
      check("words_b_17", words_read_b, 16'd17);

      repeat (3) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_byte_reader.md
FIFO_BYTE_READER -- requirements
Module: fifo_byte_reader

Interface
REQ-001 Parameter LSB_FIRST, default 1, SHALL select byte order: 1 = data_out[7:0] first, 0 = data_out[31:24] first.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of words_read.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  permits new FIFO reads when high.
REQ-006 empty  input  1  FIFO empty flag.
REQ-007 data_out  input  32  FIFO read data, valid the cycle after Read_enable.
REQ-008 Read_enable  output  1  FIFO read strobe, one-cycle pulse per word.
REQ-009 byte_ready  input  1  downstream accepts byte_out this cycle.
REQ-010 byte_out  output  8  current byte.
REQ-011 byte_valid  output  1  byte_out holds a valid byte.
REQ-012 byte_last  output  1  byte_out is the 4th byte of its word.
REQ-013 words_read  output  CNT_W  count of words popped from the FIFO.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT, SEND.
REQ-016 In IDLE, Read_enable SHALL be high combinationally iff enable=1 and empty=0; in that cycle the FSM SHALL move to WAIT and words_read SHALL increment.
REQ-017 Read_enable SHALL be 0 in WAIT and SEND and whenever empty=1.
REQ-018 In WAIT, the FSM SHALL capture data_out into an internal 32-bit word register, clear the byte index to 0, and move to SEND.
REQ-019 In SEND, byte_valid SHALL be 1 and byte_out SHALL be the byte selected by the 2-bit byte index and LSB_FIRST.
REQ-020 byte_out, byte_last, and the word register SHALL be held stable while byte_valid=1 and byte_ready=0.
REQ-021 A byte SHALL transfer on a cycle with byte_valid=1 and byte_ready=1; the byte index SHALL then increment.
REQ-022 byte_last SHALL be 1 only when byte_valid=1 and the byte index is 3.
REQ-023 On transfer of the byte at index 3, the FSM SHALL return to IDLE.
REQ-024 Latency SHALL be fixed: Read_enable in cycle N, first byte_valid in cycle N+2; minimum cost is 6 cycles per word with byte_ready held high.
REQ-025 Deasserting enable during WAIT or SEND SHALL NOT abort the current word; enable is sampled only in IDLE.
REQ-026 A change on empty during WAIT or SEND SHALL have no effect.
REQ-027 words_read SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-028 byte_valid and busy SHALL be 0 in IDLE; byte_out SHALL be 0 whenever byte_valid=0.

Reset
REQ-029 Asserting reset SHALL immediately force IDLE, byte index 0, word register 0, words_read 0, byte_out 0, byte_valid 0, byte_last 0, busy 0, and Read_enable 0.
REQ-030 A word in progress when reset asserts SHALL be discarded, with no recovery.
REQ-031 The first Read_enable after reset deasserts SHALL occur no earlier than the first rising edge with reset low.

Structure
REQ-032 The FSM state enum, DATA_W=32, and BYTE_W=8 SHALL reside in the shared package fifo_pkg.
REQ-033 The block SHALL be a single module with no sub-modules; it connects to the FIFO interface as a reader alongside the existing monitor.

Verification
REQ-034 Scenario 1: FIFO holds 0x44332211, enable=1, byte_ready=1 -> Read_enable for 1 cycle, bytes 0x11,0x22,0x33,0x44 on consecutive cycles, byte_last on 0x44, words_read=1.
REQ-035 Scenario 2: LSB_FIRST=0, same word -> bytes 0x44,0x33,0x22,0x11.
REQ-036 Scenario 3: byte_ready low for 5 cycles at byte index 1 -> byte_out stays 0x22 and byte_valid stays 1 throughout, with no Read_enable.
REQ-037 Scenario 4: empty=1, enable=1 for 20 cycles -> Read_enable never asserts and busy=0; a 1-cycle Read_enable follows within 1 cycle of empty falling.
REQ-038 Scenario 5: reset asserted mid-SEND at byte index 2 -> all outputs 0 in the same cycle, no further bytes; after release a new word is read from byte 0.
REQ-039 Scenario 6: CNT_W=4, 17 words streamed -> words_read=1 after wrap, and 68 bytes are received in order.
